// File: rtl/spram_pkg.sv
// Shared definitions for spram_seq: slave register map, slave ID word and sequencer states.
// The ID-check states exist only when SPRAM_SEQ_IDCHECK_EN is defined.
package spram_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_ADDR = 3'd1;
    localparam logic [2:0] REG_WE   = 3'd2;
    localparam logic [2:0] REG_ID   = 3'd3;

    localparam logic [31:0] SPRAM_ID = 32'h8765_4321;

    typedef enum logic [3:0] {
        ST_IDLE,
`ifdef SPRAM_SEQ_IDCHECK_EN
        ST_ID_RD,
        ST_ID_CHK,
`endif
        ST_SET_WE,
        ST_SET_ADDR,
        ST_WR_STREAM,
        ST_CLR_WE,
        ST_RD_GAP,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_FIN
    } state_t;

endpackage

// File: rtl/spram_seq.sv
// spram_seq: Avalon-MM master that LOADs a valid/ready stream into the single-port RAM slave
// or DUMPs a RAM range to a valid/ready sink. Optional macro: SPRAM_SEQ_IDCHECK_EN.
module spram_seq
    import spram_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_start,
    input  logic              cmd_dump,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_write,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata
);

    state_t             state;
    state_t             state_next;
    logic               dump_r;
    logic [ADDR_W-1:0]  base_r;
    logic [LEN_W-1:0]   remaining;
    logic               zero_done;
    logic               fin_done;
    logic               id_fail;
    logic               wr_fire;
    logic               last_word;

    assign busy      = (state != ST_IDLE);
    assign done      = zero_done | fin_done | id_fail;
    assign wr_fire   = (state == ST_WR_STREAM) && in_valid;
    assign last_word = (remaining == LEN_W'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch, word counter and the DUMP output register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dump_r    <= 1'b0;
            base_r    <= '0;
            remaining <= '0;
            zero_done <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            zero_done <= 1'b0;
            if (state == ST_IDLE && cmd_start) begin
                dump_r    <= cmd_dump;
                base_r    <= cmd_base;
                remaining <= cmd_len;
                zero_done <= (cmd_len == '0);
            end else if (wr_fire || state == ST_RD_CAP) begin
                remaining <= remaining - LEN_W'(1);
            end

            if (state == ST_RD_CAP) begin
                out_valid <= 1'b1;
                out_data  <= avm_readdata;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SPRAM_SEQ_IDCHECK_EN
    logic error_r;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            error_r <= 1'b0;
        end else if (state == ST_IDLE && cmd_start) begin
            error_r <= 1'b0;
        end else if (id_fail) begin
            error_r <= 1'b1;
        end
    end

    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        avm_address   = REG_DATA;
        avm_writedata = '0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        fin_done      = 1'b0;
        id_fail       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_start && cmd_len != '0) begin
`ifdef SPRAM_SEQ_IDCHECK_EN
                    state_next = ST_ID_RD;
`else
                    state_next = cmd_dump ? ST_SET_ADDR : ST_SET_WE;
`endif
                end
            end
`ifdef SPRAM_SEQ_IDCHECK_EN
            ST_ID_RD: begin
                avm_read    = 1'b1;
                avm_address = REG_ID;
                state_next  = ST_ID_CHK;
            end
            ST_ID_CHK: begin
                if (avm_readdata == DATA_W'(SPRAM_ID)) begin
                    state_next = dump_r ? ST_SET_ADDR : ST_SET_WE;
                end else begin
                    id_fail    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            ST_SET_WE: begin
                avm_write     = 1'b1;
                avm_address   = REG_WE;
                avm_writedata = DATA_W'(1);
                state_next    = ST_SET_ADDR;
            end
            ST_SET_ADDR: begin
                avm_write     = 1'b1;
                avm_address   = REG_ADDR;
                avm_writedata = DATA_W'(base_r);
                state_next    = dump_r ? ST_RD_GAP : ST_WR_STREAM;
            end
            ST_WR_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    avm_write     = 1'b1;
                    avm_writedata = in_data;
                    if (last_word) begin
                        state_next = ST_CLR_WE;
                    end
                end
            end
            ST_CLR_WE: begin
                avm_write   = 1'b1;
                avm_address = REG_WE;
                state_next  = ST_FIN;
            end
            ST_RD_GAP: begin
                state_next = ST_RD_ISSUE;
            end
            // A read is only launched once the output register is free or being freed
            ST_RD_ISSUE: begin
                if (!out_valid || out_ready) begin
                    avm_read   = 1'b1;
                    state_next = ST_RD_CAP;
                end
            end
            ST_RD_CAP: begin
                state_next = last_word ? ST_FIN : ST_RD_ISSUE;
            end
            ST_FIN: begin
                if (!out_valid) begin
                    fin_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
